// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state encoding, requester identifiers and the reset level.
package dmem_arbiter_pkg;

  localparam logic RESET = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } dmem_requester_e;

  function automatic dmem_requester_e other_requester(input dmem_requester_e r);
    return (r == REQ_CPU) ? REQ_DBG : REQ_CPU;
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational winner select between the CPU and debug requesters.
// DMEM_ARB_ROUND_ROBIN_EN selects alternating priority on contention; otherwise the CPU always wins.
module dmem_arb_grant
  import dmem_arbiter_pkg::*;
(
  input  logic            i_cpu_valid,
  input  logic            i_dbg_valid,
  input  dmem_requester_e i_last_grant,
  output logic            o_any_valid,
  output dmem_requester_e o_winner
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    o_any_valid = i_cpu_valid | i_dbg_valid;
    o_winner    = REQ_CPU;
    if (i_cpu_valid && i_dbg_valid) begin
      o_winner = other_requester(i_last_grant);
    end else if (i_dbg_valid) begin
      o_winner = REQ_DBG;
    end
  end
`else
  // Fixed priority ignores grant history entirely.
  logic w_unused_last_grant;
  assign w_unused_last_grant = logic'(i_last_grant);

  always_comb begin
    o_any_valid = i_cpu_valid | i_dbg_valid;
    o_winner    = REQ_CPU;
    if (!i_cpu_valid && i_dbg_valid) begin
      o_winner = REQ_DBG;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a debug requester.
// Build option: DMEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration (default: fixed CPU priority).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_ADDRESS_WIDTH = 6,
  parameter int CPU_DATA_WIDTH     = 32,
  parameter int MEM_LATENCY        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_req_valid,
  output logic                          cpu_req_ready,
  input  logic                          cpu_req_we,
  input  logic [DATA_ADDRESS_WIDTH-1:0] cpu_req_addr,
  input  logic [CPU_DATA_WIDTH-1:0]     cpu_req_wdata,
  output logic                          cpu_rsp_valid,
  input  logic                          dbg_req_valid,
  output logic                          dbg_req_ready,
  input  logic                          dbg_req_we,
  input  logic [DATA_ADDRESS_WIDTH-1:0] dbg_req_addr,
  input  logic [CPU_DATA_WIDTH-1:0]     dbg_req_wdata,
  output logic                          dbg_rsp_valid,
  output logic [CPU_DATA_WIDTH-1:0]     rsp_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [DATA_ADDRESS_WIDTH-1:0] mem_addr,
  output logic [CPU_DATA_WIDTH-1:0]     mem_wdata,
  input  logic [CPU_DATA_WIDTH-1:0]     mem_rdata,
  output dmem_arb_state_e               o_dbg_state
);

  localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("dmem_arbiter: MEM_LATENCY must be at least 1");
    end
  endgenerate

  dmem_arb_state_e              r_state;
  dmem_requester_e              r_owner;
  dmem_requester_e              r_last_grant;
  logic                         r_owner_we;
  logic [CNT_W-1:0]             r_cnt;

  logic                          w_any_valid;
  dmem_requester_e               w_winner;
  logic                          w_grant;
  logic                          w_sel_we;
  logic [DATA_ADDRESS_WIDTH-1:0] w_sel_addr;
  logic [CPU_DATA_WIDTH-1:0]     w_sel_wdata;
  logic                          w_in_resp;

  dmem_arb_grant u_grant (
    .i_cpu_valid  (cpu_req_valid),
    .i_dbg_valid  (dbg_req_valid),
    .i_last_grant (r_last_grant),
    .o_any_valid  (w_any_valid),
    .o_winner     (w_winner)
  );

  assign w_sel_we    = (w_winner == REQ_DBG) ? dbg_req_we    : cpu_req_we;
  assign w_sel_addr  = (w_winner == REQ_DBG) ? dbg_req_addr  : cpu_req_addr;
  assign w_sel_wdata = (w_winner == REQ_DBG) ? dbg_req_wdata : cpu_req_wdata;

  // Handshake: a request transfers in the cycle where valid && ready are both high.
  // ready is raised only in IDLE and never depends on valid dropping; requesters hold
  // their fields stable until ready. Grant is suppressed while reset is asserted so an
  // accept can never be lost to a same-cycle reset.
  assign w_grant = (r_state == IDLE) && w_any_valid && (rst != RESET);

  assign cpu_req_ready = w_grant && (w_winner == REQ_CPU);
  assign dbg_req_ready = w_grant && (w_winner == REQ_DBG);

  assign mem_en    = w_grant;
  assign mem_we    = w_grant && w_sel_we;
  assign mem_addr  = w_grant ? w_sel_addr  : '0;
  assign mem_wdata = w_grant ? w_sel_wdata : '0;

  assign w_in_resp     = (r_state == RESP);
  assign cpu_rsp_valid = w_in_resp && (r_owner == REQ_CPU);
  assign dbg_rsp_valid = w_in_resp && (r_owner == REQ_DBG);
  assign rsp_rdata     = (w_in_resp && !r_owner_we) ? mem_rdata : '0;

  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst == RESET) begin
      r_state      <= IDLE;
      r_owner      <= REQ_CPU;
      r_last_grant <= REQ_DBG;
      r_owner_we   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            r_owner_we   <= w_sel_we;
            r_cnt        <= CNT_W'(MEM_LATENCY - 1);
            r_state      <= (MEM_LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          // cnt==1 marks the last wait cycle; the following cycle carries mem_rdata.
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
